// File: rtl/scene_streamer_if.sv
// AXI4-Stream beat bundle shared by the scene (master) and fragment (slave) streams.
// One instance per direction; the modport picks the side.
interface scene_streamer_if #(
  parameter int unsigned DataW = 32
);
  logic             tvalid;
  logic             tready;
  logic [DataW-1:0] tdata;
  logic             tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/scene_streamer.sv
// Streams a register-loaded scene payload to the ray-tracing coprocessor, then writes the
// returned fragments into a framebuffer port and reports count/length errors.
module scene_streamer #(
  parameter int unsigned PAYLOAD_WORDS = 27,
  parameter int unsigned FB_ADDR_W     = 20
) (
  input  logic                 aclk,
  input  logic                 reset,
  input  logic                 cfg_we,
  input  logic [4:0]           cfg_addr,
  input  logic [31:0]          cfg_wdata,
  input  logic [31:0]          expected_count,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [31:0]          frag_count,
  scene_streamer_if.master     m_axis,
  scene_streamer_if.slave      s_axis,
  output logic                 fb_we,
  output logic [FB_ADDR_W-1:0] fb_addr,
  output logic [31:0]          fb_wdata
);
  localparam int unsigned IdxW = $clog2(PAYLOAD_WORDS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(PAYLOAD_WORDS - 1);

  typedef enum logic [1:0] {StIdle, StSend, StRecv, StDone} state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [31:0]           exp_q, exp_d;
  logic [31:0]           frag_q, frag_d;
  logic                  err_q, err_d;
  logic [31:0]           payload_q [PAYLOAD_WORDS];
  logic [31:0]           payload_d [PAYLOAD_WORDS];
  logic                  pend_q, pend_d;
  logic [4:0]            pend_addr_q, pend_addr_d;
  logic [31:0]           pend_data_q, pend_data_d;
  logic                  fb_we_q, fb_we_d;
  logic [FB_ADDR_W-1:0]  fb_addr_q, fb_addr_d;
  logic [31:0]           fb_wdata_q, fb_wdata_d;
  logic                  in_range;

  assign in_range = ({32'd0, frag_q} < (64'd1 << FB_ADDR_W));

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    exp_d         = exp_q;
    frag_d        = frag_q;
    err_d         = err_q;
    payload_d     = payload_q;
    pend_d        = pend_q;
    pend_addr_d   = pend_addr_q;
    pend_data_d   = pend_data_q;
    fb_we_d       = 1'b0;
    fb_addr_d     = fb_addr_q;
    fb_wdata_d    = fb_wdata_q;
    busy          = 1'b1;
    done          = 1'b0;
    m_axis.tvalid = 1'b0;
    m_axis.tdata  = '0;
    m_axis.tlast  = 1'b0;
    s_axis.tready = 1'b0;

    // A write colliding with start is parked so the stream sees the old word.
    if (state_q == StIdle && cfg_we && (cfg_addr < 5'(PAYLOAD_WORDS))) begin
      if (start) begin
        pend_d      = 1'b1;
        pend_addr_d = cfg_addr;
        pend_data_d = cfg_wdata;
      end else begin
        payload_d[cfg_addr] = cfg_wdata;
      end
    end

    case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (start) begin
          exp_d   = expected_count;
          frag_d  = '0;
          err_d   = 1'b0;
          idx_d   = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        m_axis.tvalid = 1'b1;
        m_axis.tdata  = payload_q[idx_q];
        m_axis.tlast  = (idx_q == LastIdx);
        if (m_axis.tready) begin
          if (idx_q == LastIdx) state_d = StRecv;
          else                  idx_d   = idx_q + IdxW'(1);
        end
      end
      StRecv: begin
        s_axis.tready = 1'b1;
        if (s_axis.tvalid) begin
          if ((frag_q < exp_q) && in_range) begin
            fb_we_d    = 1'b1;
            fb_addr_d  = frag_q[FB_ADDR_W-1:0];
            fb_wdata_d = s_axis.tdata;
          end else begin
            err_d = 1'b1;
          end
          if (frag_q != '1) frag_d = frag_q + 32'd1;
          if (s_axis.tlast) begin
            if ((33'(frag_q) + 33'd1) != 33'(exp_q)) err_d = 1'b1;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
        if (pend_q) payload_d[pend_addr_q] = pend_data_q;
        pend_d = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      exp_q       <= '0;
      frag_q      <= '0;
      err_q       <= 1'b0;
      payload_q   <= '{default: '0};
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      fb_we_q     <= 1'b0;
      fb_addr_q   <= '0;
      fb_wdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      exp_q       <= exp_d;
      frag_q      <= frag_d;
      err_q       <= err_d;
      payload_q   <= payload_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      fb_we_q     <= fb_we_d;
      fb_addr_q   <= fb_addr_d;
      fb_wdata_q  <= fb_wdata_d;
    end
  end

  assign error      = err_q;
  assign frag_count = frag_q;
  assign fb_we      = fb_we_q;
  assign fb_addr    = fb_addr_q;
  assign fb_wdata   = fb_wdata_q;
endmodule

// File: tb/tb_scene_streamer.sv
// Randomized bench for scene_streamer: a queue-based model of the scene stream and the
// framebuffer writes, checked every cycle by one compare process.
module tb_scene_streamer;
  localparam int unsigned PW  = 27;
  localparam int unsigned FAW = 20;

  logic            aclk = 1'b0;
  logic            reset;
  logic            cfg_we;
  logic [4:0]      cfg_addr;
  logic [31:0]     cfg_wdata;
  logic [31:0]     expected_count;
  logic            start;
  logic            busy, done, error;
  logic [31:0]     frag_count;
  logic            fb_we;
  logic [FAW-1:0]  fb_addr;
  logic [31:0]     fb_wdata;

  scene_streamer_if #(.DataW(32)) m_axis ();
  scene_streamer_if #(.DataW(32)) s_axis ();

  scene_streamer #(.PAYLOAD_WORDS(PW), .FB_ADDR_W(FAW)) dut (
    .aclk           (aclk),
    .reset          (reset),
    .cfg_we         (cfg_we),
    .cfg_addr       (cfg_addr),
    .cfg_wdata      (cfg_wdata),
    .expected_count (expected_count),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .frag_count     (frag_count),
    .m_axis         (m_axis),
    .s_axis         (s_axis),
    .fb_we          (fb_we),
    .fb_addr        (fb_addr),
    .fb_wdata       (fb_wdata)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {logic [31:0] data; logic last;} beat_t;
  typedef struct packed {logic [FAW-1:0] addr; logic [31:0] data;} fbw_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          done_cnt = 0;
  logic [31:0] mdl_pay [PW];
  beat_t       exp_beats [$];
  fbw_t        exp_fb [$];
  fbw_t        fb_log [$];
  logic [31:0] m_frag;
  logic        m_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare process
  logic        prev_stall = 1'b0;
  logic        prev_lastbeat = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;
  beat_t       cur_b;
  fbw_t        cur_w;
  initial forever begin
    @(negedge aclk);
    if (reset) begin
      prev_stall    = 1'b0;
      prev_lastbeat = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", m_axis.tvalid, 1);
        check("hold_data", m_axis.tdata, prev_data);
        check("hold_last", m_axis.tlast, prev_last);
      end
      if (prev_lastbeat) begin
        check("s_ready_after_last", s_axis.tready, 1);
        check("m_valid_drop", m_axis.tvalid, 0);
      end
      prev_stall    = m_axis.tvalid && !m_axis.tready;
      prev_lastbeat = m_axis.tvalid && m_axis.tready && m_axis.tlast;
      prev_data     = m_axis.tdata;
      prev_last     = m_axis.tlast;
      if (m_axis.tvalid && m_axis.tready) begin
        if (exp_beats.size() == 0) check("extra_beat", 1, 0);
        else begin
          cur_b = exp_beats.pop_front();
          check("beat_data", m_axis.tdata, cur_b.data);
          check("beat_last", m_axis.tlast, cur_b.last);
        end
      end
      if (fb_we) begin
        fb_log.push_back('{addr: fb_addr, data: fb_wdata});
        if (exp_fb.size() == 0) check("extra_fb_write", 1, 0);
        else begin
          cur_w = exp_fb.pop_front();
          check("fb_addr", fb_addr, cur_w.addr);
          check("fb_wdata", fb_wdata, cur_w.data);
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic cfg_write(input logic [4:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
    if (a < PW) mdl_pay[a] = d;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_frag_count"}, frag_count, 0);
    check({tag, "_m_tvalid"}, m_axis.tvalid, 0);
    check({tag, "_m_tlast"}, m_axis.tlast, 0);
    check({tag, "_m_tdata"}, m_axis.tdata, 0);
    check({tag, "_s_tready"}, s_axis.tready, 0);
    check({tag, "_fb_we"}, fb_we, 0);
    check({tag, "_fb_addr"}, fb_addr, 0);
    check({tag, "_fb_wdata"}, fb_wdata, 0);
  endtask

  task automatic run_frame(input logic [31:0] exp_cnt, input int nfr, input bit toggle,
                           input bit rnd_data, input bit collide);
    int          n;
    int          gap;
    logic [31:0] d;
    for (int i = 0; i < PW; i++) exp_beats.push_back('{data: mdl_pay[i], last: (i == PW - 1)});
    fb_log.delete();
    expected_count = exp_cnt;
    start = 1'b1;
    if (collide) begin
      cfg_we = 1'b1; cfg_addr = 5'($urandom_range(0, PW - 1)); cfg_wdata = $urandom;
    end
    tick();
    start = 1'b0;
    if (collide) begin
      cfg_we = 1'b0;
      mdl_pay[cfg_addr] = cfg_wdata;
    end
    m_frag = 0;
    m_err  = 1'b0;
    check("busy_after_start", busy, 1);
    check("error_cleared", error, 0);
    // Write attempted while busy: the model ignores it.
    cfg_we = 1'b1; cfg_addr = 5'($urandom_range(0, 31)); cfg_wdata = $urandom;
    n = 0;
    while (exp_beats.size() != 0 && n < 400) begin
      m_axis.tready = toggle ? n[0] : 1'b1;
      tick();
      cfg_we = 1'b0;
      n++;
    end
    check("stream_done", exp_beats.size(), 0);
    check("stream_cycles", n, toggle ? 54 : 27);
    exp_beats.delete();
    for (int k = 0; k < nfr; k++) begin
      gap = rnd_data ? $urandom_range(0, 2) : 0;
      s_axis.tvalid = 1'b0;
      repeat (gap) tick();
      d = rnd_data ? $urandom : 32'hA0 + 32'(k);
      s_axis.tvalid = 1'b1; s_axis.tdata = d; s_axis.tlast = (k == nfr - 1);
      check("s_tready", s_axis.tready, 1);
      if ((m_frag < exp_cnt) && ({32'd0, m_frag} < (64'd1 << FAW)))
        exp_fb.push_back('{addr: m_frag[FAW-1:0], data: d});
      else m_err = 1'b1;
      if (m_frag != 32'hFFFF_FFFF) m_frag++;
      if ((k == nfr - 1) && (m_frag != exp_cnt)) m_err = 1'b1;
      tick();
    end
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    @(negedge aclk);
    check("done_pulse", done, 1);
    check("busy_in_done", busy, 1);
    check("frag_count", frag_count, m_frag);
    check("error", error, m_err);
    @(negedge aclk);
    check("done_one_cycle", done, 0);
    check("busy_cleared", busy, 0);
    check("fb_all_written", exp_fb.size(), 0);
    exp_fb.delete();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int dcnt;
    reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    expected_count = '0; start = 1'b0;
    m_axis.tready = 1'b0;
    s_axis.tvalid = 1'b0; s_axis.tdata = '0; s_axis.tlast = 1'b0;
    for (int i = 0; i < PW; i++) mdl_pay[i] = '0;
    tick(); tick();
    reset = 1'b0;
    check_all_zero("reset");

    // Basic frame with literal expectations
    for (int i = 0; i < PW; i++) cfg_write(5'(i), 32'h1000 + 32'(i));
    run_frame(4, 4, 1'b0, 1'b0, 1'b0);
    check("lit_nwrites", fb_log.size(), 4);
    for (int k = 0; k < 4 && k < fb_log.size(); k++) begin
      check("lit_addr", fb_log[k].addr, k);
      check("lit_data", fb_log[k].data, 32'hA0 + 32'(k));
    end
    check("lit_count4", frag_count, 4);
    check("lit_err0", error, 0);

    run_frame(4, 4, 1'b1, 1'b0, 1'b0);

    run_frame(4, 2, 1'b0, 1'b0, 1'b0);
    check("short_nwrites", fb_log.size(), 2);
    check("short_count", frag_count, 2);
    check("short_err", error, 1);

    run_frame(2, 4, 1'b0, 1'b0, 1'b0);
    check("long_nwrites", fb_log.size(), 2);
    if (fb_log.size() == 2) begin
      check("long_addr0", fb_log[0].addr, 0);
      check("long_addr1", fb_log[1].addr, 1);
    end
    check("long_count", frag_count, 4);
    check("long_err", error, 1);

    // Randomized frames, including zero expected count and start/cfg collisions
    for (int it = 0; it < 8; it++) begin
      for (int w = 0; w < 4; w++) cfg_write(5'($urandom_range(0, 31)), $urandom);
      run_frame(32'($urandom_range(0, 6)), $urandom_range(1, 7), 1'($urandom_range(0, 1)),
                1'b1, (it == 0) || ($urandom_range(0, 1) == 1));
    end

    // Reset during payload beat 10
    for (int i = 0; i < PW; i++) exp_beats.push_back('{data: mdl_pay[i], last: (i == PW - 1)});
    expected_count = 4; start = 1'b1;
    m_axis.tready = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    dcnt = done_cnt;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_beats.delete();
    for (int i = 0; i < PW; i++) mdl_pay[i] = '0;
    check_all_zero("midreset");
    repeat (3) tick();
    check("no_done_on_reset", done_cnt, dcnt);
    check("idle_after_reset", busy, 0);

    // Out-of-range address write is ignored; stream must carry the cleared payload
    cfg_write(5'd27, 32'hDEAD_BEEF);
    cfg_write(5'd31, 32'hCAFE_F00D);
    run_frame(1, 1, 1'b0, 1'b1, 1'b0);
    run_frame(0, 2, 1'b1, 1'b1, 1'b0);

    check("fb_queue_empty", exp_fb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
